// File: rtl/mem_stage_pkg.sv
// mem_stage shared types and widths.
// FSM encoding, datapath widths, timeout counter sizing.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memState_t;

  function automatic int ctrWidth(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mem_stage_reg.sv
// MEM/WB pipeline register.
// Loads on ld; clr loads a bubble and wins over the data path.
module MEM_Register
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              clr,
  input  logic              nxtRegWrite,
  input  logic [DATA_W-1:0] nxtData,
  input  logic [REG_W-1:0]  nxtAddr,
  output logic              regWrite,
  output logic [DATA_W-1:0] wData,
  output logic [REG_W-1:0]  wAddr
);

  // pipeline register with bubble insert
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWrite <= 1'b0;
      wData    <= '0;
      wAddr    <= '0;
    end else if (ld) begin
      if (clr) begin
        regWrite <= 1'b0;
        wData    <= '0;
        wAddr    <= '0;
      end else begin
        regWrite <= nxtRegWrite;
        wData    <= nxtData;
        wAddr    <= nxtAddr;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: branch resolve, req/ack data port, MEM/WB reg.
// Optional ACCESS timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              En,
  input  logic              Clr,
  input  logic [DATA_W-1:0] JumpAddr_i,
  input  logic [DATA_W-1:0] Result_i,
  input  logic              Zero_i,
  input  logic [DATA_W-1:0] rData2_i,
  input  logic [REG_W-1:0]  wAddr_i,
  input  logic              Branch,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite_i,
  input  logic              MemToReg,
  output logic [DATA_W-1:0] DAddr,
  output logic [DATA_W-1:0] DWData,
  output logic              DReq,
  output logic              DWe,
  input  logic [DATA_W-1:0] DRData,
  input  logic              DAck,
  output logic              PCSrc,
  output logic [DATA_W-1:0] BranchAddr,
  output logic              Stall,
  output logic              RegWrite,
  output logic [DATA_W-1:0] wData,
  output logic [REG_W-1:0]  wAddr,
  output logic              MemErr
);

  memState_t state, stateNext;
  logic pending;
  logic toHit;
  logic [DATA_W-1:0] rData;

  assign pending    = MemRead | MemWrite;
  assign DAddr      = Result_i;
  assign DWData     = rData2_i;
  assign PCSrc      = Branch & Zero_i;
  assign BranchAddr = JumpAddr_i;
  assign Stall      = ((state == IDLE) & pending)
                    | (state == ACCESS);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ctrWidth(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  logic memErrQ;

  assign toHit = (state == ACCESS) & ~DAck
               & (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign MemErr = memErrQ;

  // ACCESS cycle counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      memErrQ <= 1'b0;
    end else begin
      cnt     <= (state == ACCESS) ? cnt + CW'(1) : '0;
      memErrQ <= memErrQ | toHit;
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT_CYCLES != 0);
  assign toHit  = 1'b0;
  assign MemErr = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (pending) stateNext = ACCESS;
      ACCESS:  if (DAck | toHit) stateNext = DONE;
      DONE:    if (En) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // request strobes and read-data latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DReq  <= 1'b0;
      DWe   <= 1'b0;
      rData <= '0;
    end else if ((state == IDLE) & pending) begin
      DReq <= 1'b1;
      DWe  <= MemWrite;
    end else if ((state == ACCESS) & (DAck | toHit)) begin
      DReq  <= 1'b0;
      DWe   <= 1'b0;
      rData <= DAck ? DRData : '0;
    end
  end

  MEM_Register u_memReg (
    .clk         (clk),
    .rst         (rst),
    .ld          (En & ~Stall),
    .clr         (Clr),
    .nxtRegWrite (RegWrite_i),
    .nxtData     (MemToReg ? rData : Result_i),
    .nxtAddr     (wAddr_i),
    .regWrite    (RegWrite),
    .wData       (wData),
    .wAddr       (wAddr)
  );

endmodule
